mdu_iter: RTL and testbench
===========================

// Module: mdu_iter
// PURPOSE
//  Iterative RV32M multiply/divide responder on the core's mdu_valid/mdu_ready handshake.
//  The controller asserts mdu_valid and holds mdu_op/rs1/rs2 while the single-cycle core stalls.
//  This block captures the operands, runs a radix-2 shift-add (MUL*) or restoring-divide (DIV*/REM*) loop,
//  then pulses mdu_ready with mdu_result, which feeds the WBsel=mdu write-back path.
// PARAMETERS
//  XLEN     32  operand/result width; the iteration count equals XLEN
//  CNT_W    6   iteration counter width (>= clog2(XLEN)+1)
// PORTS
//  clk         in   1     core clock; single clock domain
//  rst         in   1     synchronous, active-high reset
//  mdu_valid   in   1     request level, held until mdu_ready
//  mdu_op      in   3     funct3: 000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  rs1         in   XLEN  dividend / multiplicand
//  rs2         in   XLEN  divisor / multiplier
//  mdu_result  out  XLEN  registered result; valid while mdu_ready=1; held until the next capture
//  mdu_ready   out  1     one-cycle completion pulse
// BEHAVIOUR
//  - Reset: state=IDLE, mdu_ready=0, mdu_result=0, counter=0, all accumulators 0. Reset applies in any state, including mid-op.
//  - FSM IDLE -> BUSY -> DONE -> IDLE. mdu_ready = (state==DONE) and is decoded from the registered state.
//  - IDLE: if mdu_valid=1 on the edge, capture op, |rs1|, |rs2|, and the sign flags; count=0; go to BUSY.
//  - BUSY: one iteration per cycle. After XLEN iterations, apply the sign fix and load mdu_result; go to DONE.
//    Latency: capture edge at cycle N, mdu_ready=1 during cycle N+XLEN+1 (33 cycles for XLEN=32).
//  - DONE: mdu_ready=1 for exactly one cycle, then IDLE unconditionally.
//    If mdu_valid is still 1 in the following IDLE cycle, it is a new request (back-to-back ops); there is no dead cycle beyond IDLE.
//  - mdu_valid=0 while BUSY: abort, return to IDLE next edge, no mdu_ready pulse, mdu_result unchanged.
//  - Operand/op changes while BUSY are ignored; only captured values are used.
//  - Signedness: MULH uses signed*signed. MULHSU uses signed rs1 and unsigned rs2. MULHU/DIVU/REMU are unsigned.
//    MUL uses the low XLEN bits of the product and is sign-agnostic. MULH* return product[2*XLEN-1:XLEN].
//  - Sign fix: the product is negated if sa^sb. The quotient is negated if sa^sb. The remainder takes the sign of the dividend (sa).
//  - Divide by zero (rs2==0, DIV*/REM*): detected in IDLE, IDLE->DONE directly, so ready appears at N+1.
//    Quotient = all ones. Remainder = rs1 unmodified.
//  - Signed overflow (DIV/REM, rs1=0x8000_0000, rs2=0xFFFF_FFFF): IDLE->DONE, ready at N+1, quotient=0x8000_0000, remainder=0.
//  - Datapath: 2*XLEN product/remainder shift register plus one XLEN+1-bit adder/subtractor shared by mul and div.
// CONFIGURATION
//  MDU_FAST_MUL_EN defined: MUL/MULH/MULHSU/MULHU use a combinational 2*XLEN signed (XLEN+1)x(XLEN+1) multiply.
//    The op goes IDLE->DONE with ready at N+1. Divide remains iterative.
//  MDU_FAST_MUL_EN undefined: all multiplies are iterative, latency XLEN+1, with no multiplier inferred.
// STRUCTURE
//  Shared package mdu_pkg holds:
//  - MDU_OP_* localparams (3-bit funct3 codes)
//  - FSM state encodings ST_IDLE/ST_BUSY/ST_DONE
//  - helpers is_div(op), is_rem(op), op_signed_a(op), op_signed_b(op)
//  One sub-module, mdu_step: combinational single iteration.
//  - inputs: mode, acc, operand
//  - outputs: next acc and the quotient bit
//  - contains the shared XLEN+1 adder
//  The top level keeps the FSM, counter, capture, and sign fix.
// TESTING
//  1 MUL rs1=7, rs2=-3 (0xFFFF_FFFD), valid held -> ready 33 cycles after capture, result 0xFFFF_FFEB; MULH same -> 0xFFFF_FFFF.
//  2 MULHU 0xFFFF_FFFF*0xFFFF_FFFF -> 0xFFFF_FFFE; MULHSU rs1=-1, rs2=0xFFFF_FFFF -> 0xFFFF_FFFF.
//  3 DIV -7/2 -> 0xFFFF_FFFD; REM -7/2 -> 0xFFFF_FFFF; DIVU 100/7 -> 14; REMU -> 2.
//  4 DIV 5/0 -> ready at N+1, 0xFFFF_FFFF; REM 5/0 -> 5; DIV 0x8000_0000/-1 -> ready N+1, 0x8000_0000; REM -> 0.
//  5 mdu_valid held through two back-to-back DIVU ops: one ready pulse per op, second capture on the IDLE cycle after DONE.
//    Then rst asserted mid-BUSY -> next cycle IDLE, ready=0, result=0, no pulse.
//  6 Drop valid at iteration 10 -> no ready and result unchanged. Repeat suite 1-2 with MDU_FAST_MUL_EN -> ready at N+1, identical results.

Source files
------------

// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_pkg
//  Purpose  : Shared opcodes, FSM state encoding, step modes and opcode
//             decode helpers for the iterative RV32M multiply/divide unit.
//  Revision : 1.0  initial release
// ============================================================================
package mdu_pkg;

  // funct3 codes of the RV32M instructions
  localparam logic [2:0] MDU_OP_MUL    = 3'b000;
  localparam logic [2:0] MDU_OP_MULH   = 3'b001;
  localparam logic [2:0] MDU_OP_MULHSU = 3'b010;
  localparam logic [2:0] MDU_OP_MULHU  = 3'b011;
  localparam logic [2:0] MDU_OP_DIV    = 3'b100;
  localparam logic [2:0] MDU_OP_DIVU   = 3'b101;
  localparam logic [2:0] MDU_OP_REM    = 3'b110;
  localparam logic [2:0] MDU_OP_REMU   = 3'b111;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_e;

  // Iteration flavour selected on the shared step datapath
  localparam logic STEP_MUL = 1'b0;
  localparam logic STEP_DIV = 1'b1;

  // DIV, DIVU, REM, REMU all live in the upper half of the funct3 space
  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic is_rem(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

  // rs1 is interpreted as two's complement
  function automatic logic op_signed_a(input logic [2:0] op);
    return (op == MDU_OP_MULH) || (op == MDU_OP_MULHSU) ||
           (op == MDU_OP_DIV)  || (op == MDU_OP_REM);
  endfunction

  // rs2 is interpreted as two's complement
  function automatic logic op_signed_b(input logic [2:0] op);
    return (op == MDU_OP_MULH) || (op == MDU_OP_DIV) || (op == MDU_OP_REM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_iter_step.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_step
//  Purpose  : One combinational radix-2 iteration on magnitudes, built around
//             a single XLEN+1 adder/subtractor.
//             MUL mode : acc = {partial_hi, multiplier}; adds the multiplicand
//                        when multiplier LSB is set, then shifts right.
//             DIV mode : acc = {remainder, dividend}; shifts left and trial
//                        subtracts the divisor (restoring). The quotient bit
//                        is returned separately; acc_o[0] is 0 in DIV mode.
//  Revision : 1.0  initial release
// ============================================================================
module mdu_step
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              mode_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   operand_i,
  output logic [2*XLEN-1:0] acc_o,
  output logic              qbit_o
);

  logic [XLEN-1:0] w_hi;
  logic [XLEN-1:0] w_lo;
  logic [XLEN:0]   w_add_a;
  logic [XLEN:0]   w_add_b;
  logic            w_add_cin;
  logic [XLEN+1:0] w_sum;

  assign w_hi = acc_i[2*XLEN-1:XLEN];
  assign w_lo = acc_i[XLEN-1:0];

  // Operand steering for the shared adder: add for MUL, subtract for DIV
  always_comb begin
    w_add_a   = {1'b0, w_hi};
    w_add_b   = '0;
    w_add_cin = 1'b0;
    if (mode_i == STEP_DIV) begin
      // Remainder shifted left with the next dividend bit; may be XLEN+1 wide
      w_add_a   = acc_i[2*XLEN-1:XLEN-1];
      w_add_b   = ~{1'b0, operand_i};
      w_add_cin = 1'b1;
    end else if (w_lo[0]) begin
      w_add_b   = {1'b0, operand_i};
    end
  end

  // For subtraction the top bit is the "no borrow" flag (a >= b)
  assign w_sum = {1'b0, w_add_a} + {1'b0, w_add_b} + {{(XLEN+1){1'b0}}, w_add_cin};

  // Result assembly: shift right for MUL, restore-or-keep for DIV
  always_comb begin
    acc_o  = {w_sum[XLEN:0], w_lo[XLEN-1:1]};
    qbit_o = 1'b0;
    if (mode_i == STEP_DIV) begin
      qbit_o = w_sum[XLEN+1];
      if (w_sum[XLEN+1]) begin
        acc_o = {w_sum[XLEN-1:0], w_lo[XLEN-2:0], 1'b0};
      end else begin
        acc_o = {acc_i[2*XLEN-2:0], 1'b0};
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mdu_iter.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_iter
//  Purpose  : Iterative RV32M multiply/divide responder on the
//             mdu_valid/mdu_ready handshake. Captures magnitudes and sign
//             flags, runs XLEN shift-add or restoring-divide steps, applies
//             the sign fix and pulses mdu_ready for one cycle.
//  Options  : MDU_FAST_MUL_EN - single-cycle combinational multiply for
//             MUL/MULH/MULHSU/MULHU; division stays iterative.
//  Revision : 1.0  initial release
// ============================================================================
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mdu_valid,
  input  logic [2:0]      mdu_op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic [XLEN-1:0] mdu_result,
  output logic            mdu_ready
);

  localparam logic [CNT_W-1:0] C_LAST_ITER = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  C_INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e        state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic              sa_q, sa_d;
  logic              sb_q, sb_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              w_sa;
  logic              w_sb;
  logic [XLEN-1:0]   w_abs_a;
  logic [XLEN-1:0]   w_abs_b;
  logic              w_div_zero;
  logic              w_div_ovf;
  logic              w_fast_hit;
  logic [XLEN-1:0]   w_fast_res;
  logic [2*XLEN-1:0] w_step_acc;
  logic              w_qbit;
  logic [2*XLEN-1:0] w_acc_nxt;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_fixed;

  // Request decode on the live inputs (used only in IDLE)
  assign w_sa       = op_signed_a(mdu_op) & rs1[XLEN-1];
  assign w_sb       = op_signed_b(mdu_op) & rs2[XLEN-1];
  assign w_abs_a    = w_sa ? -rs1 : rs1;
  assign w_abs_b    = w_sb ? -rs2 : rs2;
  assign w_div_zero = is_div(mdu_op) && (rs2 == '0);
  assign w_div_ovf  = is_div(mdu_op) && op_signed_a(mdu_op) &&
                      (rs1 == C_INT_MIN) && (rs2 == '1);

`ifdef MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] w_fast_a;
  logic [2*XLEN-1:0] w_fast_b;
  logic [2*XLEN-1:0] w_fast_p;

  // Operands are (XLEN+1)-bit signed values sign-extended to 2*XLEN; the low
  // 2*XLEN bits of the product are exact for every signedness combination.
  assign w_fast_a   = {{XLEN{w_sa}}, rs1};
  assign w_fast_b   = {{XLEN{w_sb}}, rs2};
  assign w_fast_p   = w_fast_a * w_fast_b;
  assign w_fast_hit = !is_div(mdu_op);
  assign w_fast_res = (mdu_op == MDU_OP_MUL) ? w_fast_p[XLEN-1:0]
                                             : w_fast_p[2*XLEN-1:XLEN];
`else
  assign w_fast_hit = 1'b0;
  assign w_fast_res = '0;
`endif

  mdu_step #(
    .XLEN (XLEN)
  ) u_step (
    .mode_i    (is_div(op_q) ? STEP_DIV : STEP_MUL),
    .acc_i     (acc_q),
    .operand_i (opnd_q),
    .acc_o     (w_step_acc),
    .qbit_o    (w_qbit)
  );

  // Divide inserts the new quotient bit into the freed LSB of the dividend
  assign w_acc_nxt = is_div(op_q) ? {w_step_acc[2*XLEN-1:1], w_qbit} : w_step_acc;

  // Sign fix applied to the final iteration's accumulator
  always_comb begin
    w_prod  = (sa_q ^ sb_q) ? -w_acc_nxt : w_acc_nxt;
    w_fixed = (op_q == MDU_OP_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
    if (is_rem(op_q)) begin
      w_fixed = sa_q ? -w_acc_nxt[2*XLEN-1:XLEN] : w_acc_nxt[2*XLEN-1:XLEN];
    end else if (is_div(op_q)) begin
      w_fixed = (sa_q ^ sb_q) ? -w_acc_nxt[XLEN-1:0] : w_acc_nxt[XLEN-1:0];
    end
  end

  // Next-state and datapath update for the IDLE/BUSY/DONE controller
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (mdu_valid) begin
          op_d  = mdu_op;
          sa_d  = w_sa;
          sb_d  = w_sb;
          cnt_d = '0;
          if (is_div(mdu_op)) begin
            acc_d  = {{XLEN{1'b0}}, w_abs_a};
            opnd_d = w_abs_b;
          end else begin
            acc_d  = {{XLEN{1'b0}}, w_abs_b};
            opnd_d = w_abs_a;
          end
          if (w_div_zero) begin
            result_d = is_rem(mdu_op) ? rs1 : '1;
            state_d  = ST_DONE;
          end else if (w_div_ovf) begin
            result_d = is_rem(mdu_op) ? '0 : C_INT_MIN;
            state_d  = ST_DONE;
          end else if (w_fast_hit) begin
            result_d = w_fast_res;
            state_d  = ST_DONE;
          end else begin
            state_d  = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        if (!mdu_valid) begin
          // Requester withdrew: abandon silently, keep the old result
          state_d = ST_IDLE;
        end else begin
          acc_d = w_acc_nxt;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == C_LAST_ITER) begin
            result_d = w_fixed;
            state_d  = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign mdu_ready  = (state_q == ST_DONE);
  assign mdu_result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_mdu_iter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mdu_iter
//  Purpose  : Scoreboard bench for mdu_iter. The driver pushes the expected
//             result and completion cycle from an arithmetic reference
//             model; an independent monitor pops and compares on mdu_ready.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mdu_iter;

  localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
  localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;

  logic        clk = 1'b0;
  logic        rst;
  logic        mdu_valid;
  logic [2:0]  mdu_op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [31:0] mdu_result;
  logic        mdu_ready;

  typedef struct {
    logic [31:0] res;
    int          due;
    logic [2:0]  op;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          errors   = 0;
  int          checks   = 0;
  int          cyc      = 0;
  logic [31:0] last_res = 32'h0;

  mdu_iter #(.XLEN(32), .CNT_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .mdu_valid  (mdu_valid),
    .mdu_op     (mdu_op),
    .rs1        (rs1),
    .rs2        (rs2),
    .mdu_result (mdu_result),
    .mdu_ready  (mdu_ready)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Cycle stamp used for latency checks
  always @(posedge clk) cyc <= cyc + 1;

  // RV32M reference semantics from plain 64-bit arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    case (op)
      OP_MUL:    begin t = ua * ub; return t[31:0];  end
      OP_MULH:   begin t = sa * sb; return t[63:32]; end
      OP_MULHSU: begin t = sa * ub; return t[63:32]; end
      OP_MULHU:  begin t = ua * ub; return t[63:32]; end
      OP_DIV: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        t = sa / sb; return t[31:0];
      end
      OP_DIVU: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        t = ua / ub; return t[31:0];
      end
      OP_REM: begin
        if (b == 32'h0) return a;
        t = sa % sb; return t[31:0];
      end
      default: begin
        if (b == 32'h0) return a;
        t = ua % ub; return t[31:0];
      end
    endcase
  endfunction

  // Cycles from issue to the sample that sees mdu_ready
  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && b == 32'h0) return 1;
    if ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MDU_FAST_MUL_EN
    if (!op[2]) return 1;
`endif
    return 33;
  endfunction

  // Issue one request, wait for its completion, return to an IDLE-phase cycle
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit hold);
    exp_t e;
    int   n;
    bit   got;
    mdu_op    = op;
    rs1       = a;
    rs2       = b;
    mdu_valid = 1'b1;
    e.res = ref_model(op, a, b);
    e.due = cyc + ref_latency(op, a, b);
    e.op  = op;
    sb_q.push_back(e);
    n   = 0;
    got = 1'b0;
    while (!got && n < 100) begin
      @(posedge clk); #1;
      n++;
      got = mdu_ready;
      if (!got && n == 1) begin
        // Captured values must be used; scramble the live inputs
        mdu_op = 3'($urandom_range(0, 7));
        rs1    = $urandom;
        rs2    = $urandom;
      end
    end
    if (!got) begin
      errors++;
      checks++;
      $display("FAIL timeout op=%0d: no mdu_ready within 100 cycles, required ready", op);
      sb_q.delete();
    end
    if (!hold) mdu_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  // Monitor: compare every ready pulse against the scoreboard head
  initial begin
    forever begin
      @(posedge clk); #1;
      if (mdu_ready) begin
        if (sb_q.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL unexpected_ready: got pulse result=%h at cycle %0d, required no pulse", mdu_result, cyc);
        end else begin
          mon_e = sb_q.pop_front();
          checks += 2;
          if (mdu_result !== mon_e.res) begin
            errors++;
            $display("FAIL result op=%0d: got %h, required %h", mon_e.op, mdu_result, mon_e.res);
          end
          if (cyc != mon_e.due) begin
            errors++;
            $display("FAIL latency op=%0d: ready at cycle %0d, required %0d", mon_e.op, cyc, mon_e.due);
          end
          last_res = mon_e.res;
        end
      end
    end
  end

  // Hard stop in case the bench itself wedges
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  // Stimulus
  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    int          sel;
    rst       = 1'b1;
    mdu_valid = 1'b0;
    mdu_op    = 3'd0;
    rs1       = 32'h0;
    rs2       = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    checks += 2;
    if (mdu_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b, required 0", mdu_ready); end
    if (mdu_result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h, required 00000000", mdu_result); end
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed corner cases
    run_op(OP_MUL,    32'd7,         32'hFFFF_FFFD, 1'b0);
    run_op(OP_MULH,   32'd7,         32'hFFFF_FFFD, 1'b0);
    run_op(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(OP_DIV,    32'hFFFF_FFF9, 32'd2,         1'b0);
    run_op(OP_REM,    32'hFFFF_FFF9, 32'd2,         1'b0);
    run_op(OP_DIVU,   32'd100,       32'd7,         1'b0);
    run_op(OP_REMU,   32'd100,       32'd7,         1'b0);
    run_op(OP_DIV,    32'd5,         32'd0,         1'b0);
    run_op(OP_REM,    32'd5,         32'd0,         1'b0);
    run_op(OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

    // Back-to-back with valid held high between ops
    run_op(OP_DIVU, 32'd1000,  32'd7,   1'b1);
    run_op(OP_DIVU, 32'd12345, 32'd100, 1'b0);

    // Abort after ten iterations: no pulse, result untouched
    mdu_op    = OP_DIV;
    rs1       = 32'h1234_5678;
    rs2       = 32'd3;
    mdu_valid = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    mdu_valid = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (mdu_result !== last_res) begin errors++; $display("FAIL abort_result: got %h, required %h", mdu_result, last_res); end

    // Reset in the middle of a busy operation
    mdu_op    = OP_DIVU;
    rs1       = 32'hDEAD_BEEF;
    rs2       = 32'd13;
    mdu_valid = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks += 2;
    if (mdu_ready !== 1'b0) begin errors++; $display("FAIL rst_busy_ready: got %b, required 0", mdu_ready); end
    if (mdu_result !== 32'h0) begin errors++; $display("FAIL rst_busy_result: got %h, required 00000000", mdu_result); end
    rst       = 1'b0;
    mdu_valid = 1'b0;
    last_res  = 32'h0;
    repeat (40) @(posedge clk);
    #1;

    // Randomized ops with occasional back-to-back chaining
    for (int i = 0; i < 60; i++) begin
      rop = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 9);
      ra  = (sel == 0) ? 32'h8000_0000 : (sel == 1) ? 32'($urandom_range(0, 50)) : $urandom;
      sel = $urandom_range(0, 9);
      rb  = (sel == 0) ? 32'h0 : (sel == 1) ? 32'hFFFF_FFFF : (sel == 2) ? 32'($urandom_range(1, 20)) : $urandom;
      run_op(rop, ra, rb, (i != 59) && ($urandom_range(0, 2) == 0));
    end

    repeat (5) @(posedge clk);
    #1;
    if (sb_q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL leftover: %0d expected responses never seen, required 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
